// File: rtl/mips_core_pkg.sv
// Shared core types and constants for the fetch path and later pipeline stages.
package mips_core_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_KEEP,
    PC_SEL_SEQ,
    PC_SEL_TARGET,
    PC_SEL_PENDING
  } pc_sel_e;

endpackage

// File: rtl/redirect_buffer.sv
// Single-entry redirect holding register; newest capture overwrites the held value.
module redirect_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             release_req,
  input  logic [WIDTH-1:0] capture_pc,
  output logic [WIDTH-1:0] pending_pc,
  output logic             pending_valid
);

  // Capture wins over release so a fresh redirect is never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_pc    <= '0;
      pending_valid <= 1'b0;
    end else if (capture) begin
      pending_pc    <= capture_pc;
      pending_valid <= 1'b1;
    end else if (release_req) begin
      pending_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage program counter: sequential, immediate or buffered redirect, with epoch tagging.
module fetch_pc_gen
  import mips_core_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned            EPOCH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_stall,
  input  logic                   load_pc_we,
  input  logic [ADDR_WIDTH-1:0]  load_pc_new_pc,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  output logic                   fetch_valid,
  output logic [EPOCH_WIDTH-1:0] fetch_epoch,
  output logic                   redirect_pending,
  output logic                   misalign_err
);

  fetch_state_e          state;
  fetch_state_e          next_state;
  pc_sel_e               pc_sel;
  logic                  capture;
  logic                  release_req;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pending_pc;
  logic                  pending_valid;

  assign target = {load_pc_new_pc[ADDR_WIDTH-1:2], 2'b00};

  redirect_buffer #(.WIDTH(ADDR_WIDTH)) u_redirect_buffer (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .release_req  (release_req),
    .capture_pc   (target),
    .pending_pc   (pending_pc),
    .pending_valid(pending_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH_RUN:  if (if_stall && load_pc_we) next_state = FETCH_HOLD;
      FETCH_HOLD: if (!if_stall)              next_state = FETCH_RUN;
      default:                                next_state = FETCH_RUN;
    endcase
  end

  always_comb begin
    pc_sel      = PC_SEL_KEEP;
    capture     = 1'b0;
    release_req = 1'b0;
    case (state)
      FETCH_RUN: begin
        if (!if_stall) pc_sel  = load_pc_we ? PC_SEL_TARGET : PC_SEL_SEQ;
        else           capture = load_pc_we;
      end
      FETCH_HOLD: begin
        if (if_stall) begin
          capture = load_pc_we;
        end else begin
          release_req = 1'b1;
          // A live redirect is younger than the buffered one, so it wins.
          if (load_pc_we)         pc_sel = PC_SEL_TARGET;
          else if (pending_valid) pc_sel = PC_SEL_PENDING;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc         <= RESET_PC;
      fetch_epoch      <= '0;
      fetch_valid      <= 1'b0;
      redirect_pending <= 1'b0;
      misalign_err     <= 1'b0;
    end else begin
      case (pc_sel)
        PC_SEL_SEQ:     fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        PC_SEL_TARGET:  fetch_pc <= target;
        PC_SEL_PENDING: fetch_pc <= pending_pc;
        default:        fetch_pc <= fetch_pc;
      endcase
      if (load_pc_we) fetch_epoch <= fetch_epoch + EPOCH_WIDTH'(1);
      if (load_pc_we && (load_pc_new_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
      // Every stalled redirect lands in HOLD, so this also covers wrong-path fetches.
      fetch_valid      <= (next_state == FETCH_RUN);
      redirect_pending <= (next_state == FETCH_HOLD);
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with hand-computed expected values.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        load_pc_we;
  logic [31:0] load_pc_new_pc;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [1:0]  fetch_epoch;
  logic        redirect_pending;
  logic        misalign_err;

  int n_checks;
  int n_fail;

  fetch_pc_gen #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .EPOCH_WIDTH(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_stall        (if_stall),
    .load_pc_we      (load_pc_we),
    .load_pc_new_pc  (load_pc_new_pc),
    .fetch_pc        (fetch_pc),
    .fetch_valid     (fetch_valid),
    .fetch_epoch     (fetch_epoch),
    .redirect_pending(redirect_pending),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic we, input logic [31:0] pc);
    rst = r; if_stall = s; load_pc_we = we; load_pc_new_pc = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic v,
                            input logic [1:0] ep, input logic pend, input logic mis);
    check({tag, ".pc"},      fetch_pc, pc);
    check({tag, ".valid"},   32'(fetch_valid), 32'(v));
    check({tag, ".epoch"},   32'(fetch_epoch), 32'(ep));
    check({tag, ".pending"}, 32'(redirect_pending), 32'(pend));
    check({tag, ".misalign"}, 32'(misalign_err), 32'(mis));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b1; if_stall = 1'b0; load_pc_we = 1'b0; load_pc_new_pc = '0;

    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    expect_all("reset", 32'h0, 0, 2'd0, 0, 0);

    step(0, 0, 0, 32'h0);
    expect_all("run1", 32'h4, 1, 2'd0, 0, 0);
    step(0, 1, 0, 32'h0);
    expect_all("stall_run", 32'h4, 1, 2'd0, 0, 0);
    step(0, 0, 0, 32'h0);
    expect_all("run2", 32'h8, 1, 2'd0, 0, 0);

    step(0, 0, 1, 32'h100);
    expect_all("redir", 32'h100, 1, 2'd1, 0, 0);

    step(0, 1, 1, 32'h200);
    expect_all("hold1", 32'h100, 0, 2'd2, 1, 0);
    step(0, 1, 1, 32'h300);
    expect_all("hold2", 32'h100, 0, 2'd3, 1, 0);
    step(0, 1, 0, 32'h0);
    expect_all("hold3", 32'h100, 0, 2'd3, 1, 0);
    step(0, 0, 0, 32'h0);
    expect_all("unstall", 32'h300, 1, 2'd3, 0, 0);

    step(0, 1, 1, 32'h400);
    expect_all("hold_wrap", 32'h300, 0, 2'd0, 1, 0);
    step(0, 0, 1, 32'h500);
    expect_all("live_wins", 32'h500, 1, 2'd1, 0, 0);
    step(0, 0, 0, 32'h0);
    expect_all("pend_dropped", 32'h504, 1, 2'd1, 0, 0);

    step(0, 0, 1, 32'h102);
    expect_all("misalign", 32'h100, 1, 2'd2, 0, 1);
    step(0, 0, 0, 32'h0);
    expect_all("misalign_sticky", 32'h104, 1, 2'd2, 0, 1);

    step(0, 0, 1, 32'hFFFF_FFFC);
    expect_all("to_top", 32'hFFFF_FFFC, 1, 2'd3, 0, 1);
    step(0, 0, 0, 32'h0);
    expect_all("pc_wrap", 32'h0, 1, 2'd3, 0, 1);

    step(0, 1, 1, 32'h800);
    step(0, 1, 1, 32'h804);
    expect_all("hold_pre_rst", 32'h0, 0, 2'd1, 1, 1);
    step(1, 1, 1, 32'h900);
    expect_all("rst_in_hold", 32'h0, 0, 2'd0, 0, 0);
    step(0, 0, 0, 32'h0);
    expect_all("after_rst", 32'h4, 1, 2'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
